ssd1306_spi_receiver: RTL and testbench

- Display-side responder for the 4-wire write-only SSD1306 SPI link our OLED driver produces (sclk, sdin, cs, dc, reset).
- Oversamples the link on the system clock and deserialises bytes MSB-first.
- Decodes the command subset the driver uses, and turns data bytes into framebuffer write strobes with SSD1306 address auto-increment.
- Used as a synthesizable display model and bus monitor for the pong display path.

---
 rtl/ssd1306_pkg.sv | 49 ++++
 rtl/ssd1306_spi_receiver_if.sv | 12 +
 rtl/spi_byte_deserializer.sv | 89 ++++++++
 rtl/ssd1306_spi_receiver.sv | 187 ++++++++++++++++++
 tb/tb_ssd1306_spi_receiver.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd1306_pkg.sv
// rtl/ssd1306_pkg.sv - shared opcodes, reset defaults and decoder types for the SSD1306 receiver
package ssd1306_pkg;

    // Command opcodes understood by the decoder
    localparam logic [7:0] CMD_CONTRAST    = 8'h81;
    localparam logic [7:0] CMD_ADDR_MODE   = 8'h20;
    localparam logic [7:0] CMD_COL_RANGE   = 8'h21;
    localparam logic [7:0] CMD_PAGE_RANGE  = 8'h22;
    localparam logic [7:0] CMD_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] CMD_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] CMD_CLK_DIV     = 8'hD5;
    localparam logic [7:0] CMD_PRECHARGE   = 8'hD9;
    localparam logic [7:0] CMD_VCOMH       = 8'hDB;
    localparam logic [7:0] CMD_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] CMD_DISP_OFF    = 8'hAE;
    localparam logic [7:0] CMD_DISP_ON     = 8'hAF;
    localparam logic [7:0] CMD_NORMAL      = 8'hA6;
    localparam logic [7:0] CMD_INVERT      = 8'hA7;

    // Addressing modes; 2'b11 is stored as written but behaves like page mode
    localparam logic [1:0] ADDR_MODE_HORIZ = 2'b00;
    localparam logic [1:0] ADDR_MODE_VERT  = 2'b01;
    localparam logic [1:0] ADDR_MODE_PAGE  = 2'b10;

    // Reset defaults
    localparam logic [7:0] DEF_CONTRAST    = 8'h7F;
    localparam logic [1:0] DEF_ADDR_MODE   = ADDR_MODE_PAGE;
    localparam logic [6:0] DEF_COL_START   = 7'd0;
    localparam logic [6:0] DEF_COL_END     = 7'd127;
    localparam logic [2:0] DEF_PAGE_START  = 3'd0;
    localparam logic [2:0] DEF_PAGE_END    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG1 = 2'd1,
        ST_ARG2 = 2'd2
    } dec_state_t;

    // Number of argument bytes that follow a command opcode
    function automatic logic [1:0] arg_count(input logic [7:0] op);
        case (op)
            CMD_CONTRAST, CMD_ADDR_MODE, CMD_MUX_RATIO, CMD_DISP_OFFSET,
            CMD_CLK_DIV, CMD_PRECHARGE, CMD_VCOMH, CMD_CHARGE_PUMP: arg_count = 2'd1;
            CMD_COL_RANGE, CMD_PAGE_RANGE:                          arg_count = 2'd2;
            default:                                                arg_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_receiver_if.sv
// rtl/ssd1306_spi_receiver_if.sv - 4-wire write-only SSD1306 SPI link plus display reset pin
// master: the OLED driver side (drives all pins); slave: the display model (samples all pins)
interface ssd1306_spi_receiver_if;
    logic i_sclk;   // SPI clock, data sampled on rising edge
    logic i_sdin;   // SPI data, MSB first
    logic i_cs;     // chip select, active low
    logic i_dc;     // 0 = command byte, 1 = data byte
    logic i_res_n;  // display reset, active low

    modport master (output i_sclk, i_sdin, i_cs, i_dc, i_res_n);
    modport slave  (input  i_sclk, i_sdin, i_cs, i_dc, i_res_n);
endinterface

// File: rtl/spi_byte_deserializer.sv
// rtl/spi_byte_deserializer.sv - oversampling SPI byte deserialiser with input synchronisers
// Ports: clk/reset; raw link pins i_sclk/i_sdin/i_cs/i_dc/i_res_n;
//        o_res_n_s synced reset pin; o_byte_valid pulse with o_byte and o_byte_is_data
module spi_byte_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_sclk,
    input  logic       i_sdin,
    input  logic       i_cs,
    input  logic       i_dc,
    input  logic       i_res_n,
    output logic       o_res_n_s,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_byte_is_data
);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_sdin_sync, r_cs_sync, r_dc_sync, r_res_n_sync;
    logic       r_sclk_prev;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_done;
    logic       r_dc_latched;

    logic w_sclk_s, w_sdin_s, w_cs_s, w_dc_s, w_rise, w_clear;

    // Synchronisers only see the system reset; the synced res_n must keep
    // tracking the pin while it holds the rest of the block in defaults.
    // cs idles high and res_n idles asserted so nothing is decoded before the
    // link has propagated through the chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclk_sync  <= '0;
            r_sdin_sync  <= '0;
            r_cs_sync    <= '1;
            r_dc_sync    <= '0;
            r_res_n_sync <= '0;
        end else begin
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0],  i_sclk};
            r_sdin_sync  <= {r_sdin_sync[SYNC_STAGES-2:0],  i_sdin};
            r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0],    i_cs};
            r_dc_sync    <= {r_dc_sync[SYNC_STAGES-2:0],    i_dc};
            r_res_n_sync <= {r_res_n_sync[SYNC_STAGES-2:0], i_res_n};
        end
    end

    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_sdin_s  = r_sdin_sync[SYNC_STAGES-1];
    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_dc_s    = r_dc_sync[SYNC_STAGES-1];
    assign o_res_n_s = r_res_n_sync[SYNC_STAGES-1];
    assign w_rise    = w_sclk_s & ~r_sclk_prev;
    assign w_clear   = reset | ~o_res_n_s;

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_sclk_prev    <= 1'b0;
            r_shift        <= 8'h00;
            r_bit_cnt      <= 3'd0;
            r_done         <= 1'b0;
            r_dc_latched   <= 1'b0;
            o_byte_valid   <= 1'b0;
            o_byte         <= 8'h00;
            o_byte_is_data <= 1'b0;
        end else begin
            r_sclk_prev  <= w_sclk_s;
            r_done       <= 1'b0;
            o_byte_valid <= r_done;
            if (r_done) begin
                o_byte         <= r_shift;
                o_byte_is_data <= r_dc_latched;
            end
            // cs high wins over a coincident edge, dropping the partial byte
            if (w_cs_s) begin
                r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[6:0], w_sdin_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_done       <= 1'b1;
                    r_dc_latched <= w_dc_s;
                end
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// rtl/ssd1306_spi_receiver.sv - SSD1306 display-side SPI responder: command decode and framebuffer writes
// Ports: clk/reset; link (slave modport) carrying sclk/sdin/cs/dc/res_n;
//        byte monitor o_byte_valid/o_byte/o_byte_is_data; framebuffer o_fb_we/o_fb_addr/o_fb_wdata;
//        o_frame_done; decoded state o_display_on/o_invert/o_contrast/o_addr_mode
module ssd1306_spi_receiver
    import ssd1306_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FB_ADDR_W   = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    ssd1306_spi_receiver_if.slave link,
    output logic                 o_byte_valid,
    output logic [7:0]           o_byte,
    output logic                 o_byte_is_data,
    output logic                 o_fb_we,
    output logic [FB_ADDR_W-1:0] o_fb_addr,
    output logic [7:0]           o_fb_wdata,
    output logic                 o_frame_done,
    output logic                 o_display_on,
    output logic                 o_invert,
    output logic [7:0]           o_contrast,
    output logic [1:0]           o_addr_mode
);

    logic w_res_n_s, w_clear, w_cmd, w_data, w_at_col_end, w_at_page_end;

    dec_state_t r_state, w_state_nx;
    logic [7:0] r_opcode, w_opcode_nx;
    logic       r_display_on, w_display_on_nx;
    logic       r_invert, w_invert_nx;
    logic [7:0] r_contrast, w_contrast_nx;
    logic [1:0] r_addr_mode, w_addr_mode_nx;
    logic [6:0] r_col_start, w_col_start_nx, r_col_end, w_col_end_nx, r_col_ptr, w_col_ptr_nx;
    logic [2:0] r_page_start, w_page_start_nx, r_page_end, w_page_end_nx, r_page_ptr, w_page_ptr_nx;

    spi_byte_deserializer #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
        .clk            (clk),
        .reset          (reset),
        .i_sclk         (link.i_sclk),
        .i_sdin         (link.i_sdin),
        .i_cs           (link.i_cs),
        .i_dc           (link.i_dc),
        .i_res_n        (link.i_res_n),
        .o_res_n_s      (w_res_n_s),
        .o_byte_valid   (o_byte_valid),
        .o_byte         (o_byte),
        .o_byte_is_data (o_byte_is_data)
    );

    assign w_clear       = reset | ~w_res_n_s;
    assign w_cmd         = o_byte_valid & ~o_byte_is_data;
    assign w_data        = o_byte_valid &  o_byte_is_data;
    assign w_at_col_end  = (r_col_ptr == r_col_end);
    assign w_at_page_end = (r_page_ptr == r_page_end);

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state      <= ST_IDLE;
            r_opcode     <= 8'h00;
            r_display_on <= 1'b0;
            r_invert     <= 1'b0;
            r_contrast   <= DEF_CONTRAST;
            r_addr_mode  <= DEF_ADDR_MODE;
            r_col_start  <= DEF_COL_START;
            r_col_end    <= DEF_COL_END;
            r_page_start <= DEF_PAGE_START;
            r_page_end   <= DEF_PAGE_END;
            r_col_ptr    <= 7'd0;
            r_page_ptr   <= 3'd0;
        end else begin
            r_state      <= w_state_nx;
            r_opcode     <= w_opcode_nx;
            r_display_on <= w_display_on_nx;
            r_invert     <= w_invert_nx;
            r_contrast   <= w_contrast_nx;
            r_addr_mode  <= w_addr_mode_nx;
            r_col_start  <= w_col_start_nx;
            r_col_end    <= w_col_end_nx;
            r_page_start <= w_page_start_nx;
            r_page_end   <= w_page_end_nx;
            r_col_ptr    <= w_col_ptr_nx;
            r_page_ptr   <= w_page_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_opcode_nx      = r_opcode;
        w_display_on_nx  = r_display_on;
        w_invert_nx      = r_invert;
        w_contrast_nx    = r_contrast;
        w_addr_mode_nx   = r_addr_mode;
        w_col_start_nx   = r_col_start;
        w_col_end_nx     = r_col_end;
        w_page_start_nx  = r_page_start;
        w_page_end_nx    = r_page_end;
        w_col_ptr_nx     = r_col_ptr;
        w_page_ptr_nx    = r_page_ptr;

        // Only command bytes move the decoder; data bytes leave it waiting
        if (w_cmd) begin
            case (r_state)
                ST_IDLE: begin
                    if (arg_count(o_byte) != 2'd0) begin
                        w_state_nx  = ST_ARG1;
                        w_opcode_nx = o_byte;
                    end else begin
                        case (o_byte)
                            CMD_DISP_OFF: w_display_on_nx = 1'b0;
                            CMD_DISP_ON:  w_display_on_nx = 1'b1;
                            CMD_NORMAL:   w_invert_nx     = 1'b0;
                            CMD_INVERT:   w_invert_nx     = 1'b1;
                            default: begin
                                if (o_byte[7:3] == 5'b10110)
                                    w_page_ptr_nx = o_byte[2:0];
                                else if (o_byte[7:4] == 4'h0)
                                    w_col_ptr_nx[3:0] = o_byte[3:0];
                                else if (o_byte[7:3] == 5'b00010)
                                    w_col_ptr_nx[6:4] = o_byte[2:0];
                            end
                        endcase
                    end
                end
                ST_ARG1: begin
                    case (r_opcode)
                        CMD_CONTRAST:  w_contrast_nx  = o_byte;
                        CMD_ADDR_MODE: w_addr_mode_nx = o_byte[1:0];
                        CMD_COL_RANGE: begin
                            w_col_start_nx = o_byte[6:0];
                            w_col_ptr_nx   = o_byte[6:0];
                        end
                        CMD_PAGE_RANGE: begin
                            w_page_start_nx = o_byte[2:0];
                            w_page_ptr_nx   = o_byte[2:0];
                        end
                        default: ;
                    endcase
                    w_state_nx = (arg_count(r_opcode) == 2'd2) ? ST_ARG2 : ST_IDLE;
                end
                ST_ARG2: begin
                    if (r_opcode == CMD_COL_RANGE)
                        w_col_end_nx = o_byte[6:0];
                    else if (r_opcode == CMD_PAGE_RANGE)
                        w_page_end_nx = o_byte[2:0];
                    w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end

        // End-of-range checks take priority over the increment
        if (w_data) begin
            case (r_addr_mode)
                ADDR_MODE_HORIZ: begin
                    if (w_at_col_end) begin
                        w_col_ptr_nx  = r_col_start;
                        w_page_ptr_nx = w_at_page_end ? r_page_start : r_page_ptr + 3'd1;
                    end else begin
                        w_col_ptr_nx  = r_col_ptr + 7'd1;
                    end
                end
                ADDR_MODE_VERT: begin
                    if (w_at_page_end) begin
                        w_page_ptr_nx = r_page_start;
                        w_col_ptr_nx  = w_at_col_end ? r_col_start : r_col_ptr + 7'd1;
                    end else begin
                        w_page_ptr_nx = r_page_ptr + 3'd1;
                    end
                end
                default: w_col_ptr_nx = w_at_col_end ? r_col_start : r_col_ptr + 7'd1;
            endcase
        end
    end

    assign o_fb_we      = w_data;
    assign o_fb_addr    = FB_ADDR_W'({r_page_ptr, r_col_ptr});
    assign o_fb_wdata   = o_byte;
    assign o_frame_done = w_data & ((r_addr_mode == ADDR_MODE_HORIZ) | (r_addr_mode == ADDR_MODE_VERT))
                        & w_at_col_end & w_at_page_end;
    assign o_display_on = r_display_on;
    assign o_invert     = r_invert;
    assign o_contrast   = r_contrast;
    assign o_addr_mode  = r_addr_mode;

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// tb/tb_ssd1306_spi_receiver.sv - self-checking bench for ssd1306_spi_receiver
module tb_ssd1306_spi_receiver;

    localparam int HALF = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ssd1306_spi_receiver_if link();

    logic       o_byte_valid, o_byte_is_data, o_fb_we, o_frame_done, o_display_on, o_invert;
    logic [7:0] o_byte, o_fb_wdata, o_contrast;
    logic [9:0] o_fb_addr;
    logic [1:0] o_addr_mode;

    ssd1306_spi_receiver #(.SYNC_STAGES(2), .FB_ADDR_W(10)) dut (
        .clk            (clk),
        .reset          (reset),
        .link           (link),
        .o_byte_valid   (o_byte_valid),
        .o_byte         (o_byte),
        .o_byte_is_data (o_byte_is_data),
        .o_fb_we        (o_fb_we),
        .o_fb_addr      (o_fb_addr),
        .o_fb_wdata     (o_fb_wdata),
        .o_frame_done   (o_frame_done),
        .o_display_on   (o_display_on),
        .o_invert       (o_invert),
        .o_contrast     (o_contrast),
        .o_addr_mode    (o_addr_mode)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every completed byte with the framebuffer signals seen alongside it
    typedef struct {
        logic [7:0] b;
        logic       d;
        logic       we;
        logic [9:0] a;
        logic [7:0] w;
        logic       fd;
    } ev_t;
    ev_t evq[$];
    ev_t last_ev;
    int  stray = 0;

    always @(negedge clk) begin
        if (o_byte_valid === 1'b1)
            evq.push_back('{o_byte, o_byte_is_data, o_fb_we, o_fb_addr, o_fb_wdata, o_frame_done});
        else if (o_fb_we === 1'b1 || o_frame_done === 1'b1)
            stray++;
    end

    // Reference model: display state kept as plain integers, pending arguments as a queue of sinks
    localparam int P_CONTRAST = 0, P_MODE = 1, P_CS = 2, P_CE = 3, P_PS = 4, P_PE = 5, P_DROP = 6;
    int m_disp, m_inv, m_contrast, m_mode, m_cs, m_ce, m_ps, m_pe, m_col, m_page;
    int m_pend[$];

    task automatic model_reset();
        m_disp = 0; m_inv = 0; m_contrast = 127; m_mode = 2;
        m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_col = 0; m_page = 0;
        m_pend.delete();
    endtask

    task automatic model_apply(input logic dc, input logic [7:0] b);
        int v;
        int code;
        v = int'(b);
        if (dc) begin
            if (m_mode == 0) begin
                if (m_col == m_ce) begin
                    m_col  = m_cs;
                    m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
                end else m_col = (m_col + 1) % 128;
            end else if (m_mode == 1) begin
                if (m_page == m_pe) begin
                    m_page = m_ps;
                    m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
                end else m_page = (m_page + 1) % 8;
            end else begin
                m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
            end
        end else if (m_pend.size() > 0) begin
            code = m_pend.pop_front();
            case (code)
                P_CONTRAST: m_contrast = v;
                P_MODE:     m_mode = v % 4;
                P_CS:       begin m_cs = v % 128; m_col = m_cs; end
                P_CE:       m_ce = v % 128;
                P_PS:       begin m_ps = v % 8; m_page = m_ps; end
                P_PE:       m_pe = v % 8;
                default: ;
            endcase
        end else begin
            if (v == 'h81) m_pend.push_back(P_CONTRAST);
            else if (v == 'h20) m_pend.push_back(P_MODE);
            else if (v == 'h21) begin m_pend.push_back(P_CS); m_pend.push_back(P_CE); end
            else if (v == 'h22) begin m_pend.push_back(P_PS); m_pend.push_back(P_PE); end
            else if (v == 'hA8 || v == 'hD3 || v == 'hD5 || v == 'hD9 || v == 'hDB || v == 'h8D)
                m_pend.push_back(P_DROP);
            else if (v == 'hAE) m_disp = 0;
            else if (v == 'hAF) m_disp = 1;
            else if (v == 'hA6) m_inv = 0;
            else if (v == 'hA7) m_inv = 1;
            else if (v >= 'hB0 && v <= 'hB7) m_page = v - 'hB0;
            else if (v <= 'h0F) m_col = (m_col / 16) * 16 + v;
            else if (v >= 'h10 && v <= 'h17) m_col = (m_col % 16) + (v - 'h10) * 16;
        end
    endtask

    // Link driver; all calls start just after a falling clk edge
    task automatic spi_bit(input logic v);
        link.i_sdin = v;
        link.i_sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        link.i_sclk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic spi_byte(input logic dc, input logic [7:0] b);
        link.i_cs = 1'b0;
        link.i_dc = dc;
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
        link.i_sclk = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic wait_event(input string name);
        for (int i = 0; i < 30 && evq.size() == 0; i++) @(negedge clk);
        chk({name, "_byte_seen"}, (evq.size() > 0), 1);
        if (evq.size() > 0) last_ev = evq.pop_front();
    endtask

    task automatic check_regs(input string name);
        chk({name, "_display_on"}, o_display_on, m_disp);
        chk({name, "_invert"},     o_invert,     m_inv);
        chk({name, "_contrast"},   o_contrast,   m_contrast);
        chk({name, "_addr_mode"},  o_addr_mode,  m_mode);
    endtask

    task automatic send_and_check(input string name, input logic dc, input logic [7:0] b);
        int  exp_addr;
        logic exp_fd;
        exp_addr = m_page * 128 + m_col;
        exp_fd   = dc && (m_mode == 0 || m_mode == 1) && m_page == m_pe && m_col == m_ce;
        model_apply(dc, b);
        spi_byte(dc, b);
        wait_event(name);
        chk({name, "_byte"},    last_ev.b,  b);
        chk({name, "_is_data"}, last_ev.d,  dc);
        chk({name, "_fb_we"},   last_ev.we, dc);
        chk({name, "_frame"},   last_ev.fd, exp_fd);
        if (dc) begin
            chk({name, "_fb_addr"},  last_ev.a, exp_addr);
            chk({name, "_fb_wdata"}, last_ev.w, b);
        end
        repeat (2) @(negedge clk);
        chk({name, "_single"}, evq.size(), 0);
        check_regs(name);
    endtask

    typedef struct {
        logic       dc;
        logic [7:0] b;
        logic       we;
        logic [9:0] a;
        logic       fd;
    } vec_t;
    vec_t tbl[14];

    logic [7:0] cmd_pool[16];

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [7:0] b;
        logic dc;

        tbl[0]  = '{1'b0, 8'hAF, 1'b0, 10'h000, 1'b0};
        tbl[1]  = '{1'b0, 8'h20, 1'b0, 10'h000, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 10'h000, 1'b0};
        tbl[3]  = '{1'b0, 8'h21, 1'b0, 10'h000, 1'b0};
        tbl[4]  = '{1'b0, 8'h10, 1'b0, 10'h000, 1'b0};
        tbl[5]  = '{1'b0, 8'h11, 1'b0, 10'h000, 1'b0};
        tbl[6]  = '{1'b0, 8'h22, 1'b0, 10'h000, 1'b0};
        tbl[7]  = '{1'b0, 8'h02, 1'b0, 10'h000, 1'b0};
        tbl[8]  = '{1'b0, 8'h03, 1'b0, 10'h000, 1'b0};
        tbl[9]  = '{1'b1, 8'h01, 1'b1, 10'h110, 1'b0};
        tbl[10] = '{1'b1, 8'h02, 1'b1, 10'h111, 1'b0};
        tbl[11] = '{1'b1, 8'h03, 1'b1, 10'h190, 1'b0};
        tbl[12] = '{1'b1, 8'h04, 1'b1, 10'h191, 1'b1};
        tbl[13] = '{1'b1, 8'h05, 1'b1, 10'h110, 1'b0};

        cmd_pool = '{8'h81, 8'h20, 8'h21, 8'h22, 8'hAE, 8'hAF, 8'hA6, 8'hA7,
                     8'hB3, 8'hB6, 8'h05, 8'h0C, 8'h13, 8'h16, 8'hA8, 8'hE3};

        link.i_sclk = 1'b0; link.i_sdin = 1'b0; link.i_cs = 1'b1;
        link.i_dc = 1'b0; link.i_res_n = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state while reset is still held
        chk("rst_byte_valid", o_byte_valid, 0);
        chk("rst_byte",       o_byte,       0);
        chk("rst_is_data",    o_byte_is_data, 0);
        chk("rst_fb_we",      o_fb_we,      0);
        chk("rst_fb_addr",    o_fb_addr,    0);
        chk("rst_fb_wdata",   o_fb_wdata,   0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_display_on", o_display_on, 0);
        chk("rst_invert",     o_invert,     0);
        chk("rst_contrast",   o_contrast,   8'h7F);
        chk("rst_addr_mode",  o_addr_mode,  2);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        model_reset();

        // Test plan vectors
        for (int i = 0; i < 14; i++) begin
            send_and_check($sformatf("vec%0d", i), tbl[i].dc, tbl[i].b);
            chk($sformatf("vec%0d_tbl_we", i), last_ev.we, tbl[i].we);
            chk($sformatf("vec%0d_tbl_fd", i), last_ev.fd, tbl[i].fd);
            if (tbl[i].we) chk($sformatf("vec%0d_tbl_addr", i), last_ev.a, tbl[i].a);
        end
        chk("tbl_display_on", o_display_on, 1);

        // Latency from the first clk edge that samples sclk high on the last bit
        link.i_cs = 1'b0; link.i_dc = 1'b0;
        for (int i = 7; i >= 1; i--) spi_bit(1'b1);
        link.i_sdin = 1'b0; link.i_sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        link.i_sclk = 1'b1;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (o_byte_valid === 1'b1 && lat == 0) lat = i;
        end
        chk("latency_cycles", lat, 4);
        link.i_sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        model_apply(1'b0, 8'hFE);
        wait_event("latency");
        chk("latency_byte", last_ev.b, 8'hFE);

        // Partial byte aborted by cs
        link.i_cs = 1'b0; link.i_dc = 1'b0;
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        link.i_cs = 1'b1;
        repeat (10) @(negedge clk);
        link.i_sclk = 1'b0;
        repeat (2) @(negedge clk);
        chk("partial_no_byte", evq.size(), 0);
        send_and_check("after_cs", 1'b0, 8'hA5);

        // Page mode pointer setup
        send_and_check("pm_mode",   1'b0, 8'h20);
        send_and_check("pm_mode_a", 1'b0, 8'h02);
        send_and_check("pm_page",   1'b0, 8'hB5);
        send_and_check("pm_col_lo", 1'b0, 8'h03);
        send_and_check("pm_col_hi", 1'b0, 8'h12);
        send_and_check("pm_data",   1'b1, 8'hFF);
        chk("pm_fixed_addr",  last_ev.a, 10'h2A3);
        chk("pm_fixed_wdata", last_ev.w, 8'hFF);

        // Display reset pin mid-command
        send_and_check("rn_on",  1'b0, 8'hAF);
        send_and_check("rn_inv", 1'b0, 8'hA7);
        send_and_check("rn_op",  1'b0, 8'h81);
        link.i_res_n = 1'b0;
        repeat (8) @(negedge clk);
        chk("rn_held_display_on", o_display_on, 0);
        chk("rn_held_addr_mode",  o_addr_mode,  2);
        link.i_res_n = 1'b1;
        repeat (6) @(negedge clk);
        model_reset();
        check_regs("rn_after");
        send_and_check("rn_op2",  1'b0, 8'h81);
        send_and_check("rn_arg",  1'b0, 8'h40);
        chk("rn_contrast_fixed", o_contrast, 8'h40);
        send_and_check("rn_data", 1'b1, 8'h5A);

        // Randomised traffic against the model
        for (int i = 0; i < 80; i++) begin
            dc = ($urandom_range(0, 2) == 0);
            if (dc || $urandom_range(0, 1) == 0) b = 8'($urandom_range(0, 255));
            else b = cmd_pool[$urandom_range(0, 15)];
            send_and_check($sformatf("rnd%0d", i), dc, b);
        end

        chk("stray_fb_strobes", stray, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
